// File: rtl/perf_pkg.sv
// Shared types and defaults for the pipeline performance monitor.
// The counter saturation mode is selected by the PERF_SATURATE_EN macro.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } perf_state_e;

  localparam int CNT_W_DEF = 32;
  localparam int LIM_W_DEF = 32;

endpackage

// File: rtl/perf_evt_counter.sv
// One performance counter with increment enable, synchronous clear and sticky overflow.
// Wraps modulo 2^CNT_W by default; saturates at all-ones when PERF_SATURATE_EN is defined.
module perf_evt_counter
  import perf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             at_max;

  assign at_max = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (at_max) begin
        // Overflow is flagged on the increment that would leave all-ones.
        ovf_d = 1'b1;
`ifdef PERF_SATURATE_EN
        cnt_d = cnt_q;
`else
        cnt_d = '0;
`endif
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Cycle plus per-event performance counters over a programmable run window, with a registered read port.
// Counter behaviour on overflow (wrap or saturate) follows the PERF_SATURATE_EN macro.
module pipe_perf_monitor
  import perf_pkg::*;
#(
  parameter  int NUM_EVT = 4,
  parameter  int CNT_W   = CNT_W_DEF,
  parameter  int LIM_W   = LIM_W_DEF,
  localparam int SEL_W   = $clog2(NUM_EVT + 2)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic               freeze_i,
  input  logic [LIM_W-1:0]   limit_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [NUM_EVT:0]   ovf_o,
  output logic               running_o,
  output logic               done_o
);

  localparam int SEL_CYCLE = NUM_EVT;
  localparam int CMP_W     = ((CNT_W > LIM_W) ? CNT_W : LIM_W) + 1;

  perf_state_e      state_q, state_d;
  logic [LIM_W-1:0] limit_q, limit_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             running_q, done_q;

  logic [CNT_W-1:0] cnt_w [NUM_EVT+1];
  logic [NUM_EVT:0] ovf_w;
  logic [NUM_EVT:0] inc_w;
  logic             count_en;
  logic             hit_limit;

  assign count_en = (state_q == ST_RUN) && !freeze_i;

  // Compared one bit wider than either operand so limit-1 -> limit never aliases on wrap.
  assign hit_limit = (limit_q != '0) &&
                     ((CMP_W'(cnt_w[SEL_CYCLE]) + CMP_W'(1)) == CMP_W'(limit_q));

  assign inc_w = {count_en, evt_i & {NUM_EVT{count_en}}};

  for (genvar k = 0; k <= NUM_EVT; k++) begin : g_cnt
    perf_evt_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .inc_i (inc_w[k]),
      .cnt_o (cnt_w[k]),
      .ovf_o (ovf_w[k])
    );
  end

  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_RUN;
            limit_d = limit_i;
          end
        end
        ST_RUN: begin
          if (count_en && hit_limit) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Read mux samples counters before this edge's update; out-of-range selects read zero.
  always_comb begin
    rd_data_d = '0;
    for (int k = 0; k <= NUM_EVT; k++) begin
      if (rd_sel_i == SEL_W'(k)) begin
        rd_data_d = cnt_w[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      limit_q   <= '0;
      rd_data_q <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      limit_q   <= limit_d;
      rd_data_q <= rd_data_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign rd_data_o = rd_data_q;
  assign ovf_o     = ovf_w;
  assign running_o = running_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Self-checking bench for pipe_perf_monitor (NUM_EVT=2, CNT_W=8); honours PERF_SATURATE_EN.
module tb_pipe_perf_monitor;

  localparam int NE = 2;
  localparam int CW = 8;
  localparam int LW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0, clr = 1'b0, start = 1'b0, frz = 1'b0;
  logic [LW-1:0] lim = '0;
  logic [NE-1:0] evt = '0;
  logic [1:0]    sel = '0;
  logic [CW-1:0] rd_data;
  logic [NE:0]   ovf;
  logic          running, done;

  int total = 0;
  int bad   = 0;

  // Reference model state: counts[NE] is the cycle counter; st 0=idle 1=run 2=done.
  int       m_cnt [NE+1];
  bit [NE:0] m_ovf;
  int       m_st, m_lim, m_rd;

  pipe_perf_monitor #(.NUM_EVT(NE), .CNT_W(CW), .LIM_W(LW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clr), .freeze_i(frz),
    .limit_i(lim), .evt_i(evt), .rd_sel_i(sel), .rd_data_o(rd_data),
    .ovf_o(ovf), .running_o(running), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic bump(input int k);
    if (m_cnt[k] == CMAX) begin
      m_ovf[k] = 1'b1;
`ifdef PERF_SATURATE_EN
      m_cnt[k] = CMAX;
`else
      m_cnt[k] = 0;
`endif
    end else begin
      m_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  task automatic model_edge();
    int old_cyc;
    if (rst) begin
      foreach (m_cnt[k]) m_cnt[k] = 0;
      m_ovf = '0; m_st = 0; m_lim = 0; m_rd = 0;
    end else begin
      m_rd = (int'(sel) <= NE) ? m_cnt[sel] : 0;
      if (clr) begin
        foreach (m_cnt[k]) m_cnt[k] = 0;
        m_ovf = '0; m_st = 0;
      end else if (m_st == 0) begin
        if (start) begin m_st = 1; m_lim = int'(lim); end
      end else if (m_st == 1 && !frz) begin
        old_cyc = m_cnt[NE];
        for (int k = 0; k < NE; k++) if (evt[k]) bump(k);
        bump(NE);
        if (m_lim != 0 && old_cyc + 1 == m_lim) m_st = 2;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".rd"},   int'(rd_data), m_rd);
    chk({tag, ".ovf"},  int'(ovf),     int'(m_ovf));
    chk({tag, ".run"},  int'(running), int'(m_st == 1));
    chk({tag, ".done"}, int'(done),    int'(m_st == 2));
  endtask

  task automatic quiet();
    rst = 0; clr = 0; start = 0; frz = 0; evt = '0;
  endtask

  task automatic read_chk(input string name, input int s, input int exp);
    quiet();
    sel = 2'(s);
    step();
    cmp_model(name);
    chk(name, int'(rd_data), exp);
  endtask

  typedef struct {
    bit        rst, clr, start, frz;
    int        lim;
    bit [1:0]  evt, sel;
    int        e_rd;
    bit        e_run, e_done;
    bit [2:0]  e_ovf;
  } vec_t;

  vec_t tbl [10];

  initial begin
    foreach (m_cnt[k]) m_cnt[k] = 0;
    m_ovf = '0; m_st = 0; m_lim = 0; m_rd = 0;

    //           rst clr st frz lim evt  sel  rd run done ovf
    tbl[0] = '{1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 3'd0};
    tbl[1] = '{0, 0, 1, 0, 3, 2'd0, 2'd0, 0, 1, 0, 3'd0};
    tbl[2] = '{0, 0, 0, 0, 0, 2'd1, 2'd0, 0, 1, 0, 3'd0};
    tbl[3] = '{0, 0, 0, 0, 0, 2'd1, 2'd0, 1, 1, 0, 3'd0};
    tbl[4] = '{0, 0, 0, 0, 0, 2'd1, 2'd2, 2, 0, 1, 3'd0};
    tbl[5] = '{0, 0, 1, 0, 0, 2'd3, 2'd0, 3, 0, 1, 3'd0};
    tbl[6] = '{0, 0, 0, 0, 0, 2'd0, 2'd2, 3, 0, 1, 3'd0};
    tbl[7] = '{0, 0, 0, 0, 0, 2'd0, 2'd3, 0, 0, 1, 3'd0};
    tbl[8] = '{0, 1, 1, 0, 0, 2'd0, 2'd0, 3, 0, 0, 3'd0};
    tbl[9] = '{0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 3'd0};

    #1;
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst; clr = tbl[i].clr; start = tbl[i].start; frz = tbl[i].frz;
      lim = LW'(tbl[i].lim); evt = tbl[i].evt; sel = tbl[i].sel;
      step();
      chk($sformatf("tbl%0d.rd", i),   int'(rd_data), tbl[i].e_rd);
      chk($sformatf("tbl%0d.run", i),  int'(running), int'(tbl[i].e_run));
      chk($sformatf("tbl%0d.done", i), int'(done),    int'(tbl[i].e_done));
      chk($sformatf("tbl%0d.ovf", i),  int'(ovf),     int'(tbl[i].e_ovf));
    end

    // Ten-cycle window, evt1 on alternate cycles.
    quiet(); sel = 0; start = 1; lim = 10; step(); cmp_model("t1.start");
    for (int i = 0; i < 10; i++) begin
      quiet(); evt = {(i % 2 == 0), 1'b1}; step(); cmp_model("t1.run");
      chk("t1.done_edge", int'(done), int'(i == 9));
    end
    read_chk("t1.cnt0", 0, 10);
    read_chk("t1.cnt1", 1, 5);
    read_chk("t1.cyc", 2, 10);
    quiet(); clr = 1; step(); cmp_model("t1.clr");

    // 256 events with unlimited window: wrap or saturate.
    quiet(); start = 1; lim = 0; step();
    for (int i = 0; i < 256; i++) begin
      quiet(); evt = 2'b01; step(); cmp_model("t2.run");
      if (i == 254) chk("t2.ovf_pre", int'(ovf[0]), 0);
    end
    chk("t2.ovf0", int'(ovf[0]), 1);
`ifdef PERF_SATURATE_EN
    read_chk("t2.cnt0", 0, 255);
`else
    read_chk("t2.cnt0", 0, 0);
`endif
    chk("t2.still_run", int'(running), 1);
    quiet(); clr = 1; step(); cmp_model("t2.clr");

    // Freeze for 5 cycles inside a 20-cycle window.
    quiet(); start = 1; lim = 20; step();
    for (int e = 1; e <= 25; e++) begin
      quiet(); evt = 2'b01; frz = (e >= 8 && e <= 12); step(); cmp_model("t3.run");
      chk("t3.done_edge", int'(done), int'(e == 25));
    end
    read_chk("t3.cyc", 2, 20);
    read_chk("t3.cnt0", 0, 20);

    // Clear with start in IDLE, then clear mid-run with events active.
    quiet(); clr = 1; start = 1; lim = 5; step(); cmp_model("t4.clrstart");
    chk("t4.idle", int'(running), 0);
    quiet(); start = 1; lim = 0; step();
    for (int i = 0; i < 6; i++) begin quiet(); evt = 2'b11; step(); end
    quiet(); clr = 1; evt = 2'b11; step(); cmp_model("t4.clr");
    chk("t4.run_off", int'(running), 0);
    chk("t4.ovf", int'(ovf), 0);
    read_chk("t4.cnt0", 0, 0);
    read_chk("t4.cyc", 2, 0);

    // Reset mid-run, then start ignored in DONE.
    quiet(); start = 1; lim = 0; step();
    for (int i = 0; i < 7; i++) begin quiet(); evt = 2'b11; sel = 0; step(); end
    quiet(); rst = 1; step(); cmp_model("t5.rst");
    chk("t5.rd0", int'(rd_data), 0);
    chk("t5.run0", int'(running), 0);
    chk("t5.done0", int'(done), 0);
    quiet(); start = 1; lim = 3; step();
    for (int i = 0; i < 3; i++) begin quiet(); evt = 2'b01; step(); end
    quiet(); start = 1; evt = 2'b11; lim = 50; step(); cmp_model("t5.done_start");
    chk("t5.done_hold", int'(done), 1);
    read_chk("t5.cnt0", 0, 3);

    // Out-of-range select and read-before-update timing.
    read_chk("t6.sel3", 3, 0);
    quiet(); clr = 1; step();
    quiet(); start = 1; lim = 0; step();
    for (int i = 0; i < 4; i++) begin quiet(); evt = 2'b01; step(); end
    quiet(); evt = 2'b01; sel = 0; step(); cmp_model("t6.rd");
    chk("t6.old_value", int'(rd_data), 4);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom % 200) == 0;
      clr   = ($urandom % 100) == 0;
      start = ($urandom % 8) == 0;
      frz   = ($urandom % 4) == 0;
      lim   = ($urandom % 2) ? LW'($urandom_range(1, 40)) : '0;
      evt   = NE'($urandom);
      sel   = 2'($urandom);
      step();
      cmp_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_perf_monitor.md
Name: pipe_perf_monitor

Overview:
Synthesizable per-event performance counter unit for the pipelined CPU; replaces bench-side stall/flush counting and fixed-cycle stop logic. Counts cycles plus NUM_EVT event channels (stall, flush, retire, ...) over a programmable run window. Raises a done flag when the window ends and exposes any counter through a registered read port. Sits beside CPU, fed by hazard-unit and control strobes.

Parameters:
NUM_EVT, 4, number of event channels (1..16)
CNT_W, 32, width of every counter, including the cycle counter
LIM_W, 32, width of the run-length limit

Ports:
clk_i  in  1  clock; all state changes on rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  start request; honoured only in IDLE
clear_i  in  1  zero all counters and flags, return to IDLE
freeze_i  in  1  pause counting while RUN
limit_i  in  LIM_W  run length in cycles; 0 = unlimited; latched at start
evt_i  in  NUM_EVT  per-channel event strobes, one count per high cycle
rd_sel_i  in  $clog2(NUM_EVT+2)  read select
rd_data_o  out  CNT_W  registered read data
ovf_o  out  NUM_EVT+1  sticky overflow flags; bit NUM_EVT = cycle counter
running_o  out  1  high in RUN
done_o  out  1  high in DONE

Behaviour:
- Reset: state IDLE; all counters 0; ovf_o 0; rd_data_o 0; running_o 0; done_o 0; latched limit 0.
- FSM: IDLE, RUN, DONE. Priority per edge: rst_i > clear_i > everything else.
- IDLE: start_i=1 -> RUN, limit_i latched. The start edge itself counts nothing.
- RUN, freeze_i=0: cycle counter +1; counter k +1 when evt_i[k]=1.
- RUN, freeze_i=1: no counter or flag changes; state stays RUN.
- RUN -> DONE on the edge where the cycle counter goes from limit-1 to limit (limit != 0). That edge's events are counted. Exactly `limit` unfrozen cycles are counted.
- With limit 0, RUN persists until clear_i or rst_i.
- DONE: all counters hold; start_i, freeze_i and evt_i are ignored; done_o=1; running_o=0.
- clear_i in any state: counters and ovf_o to 0; state to IDLE. A start_i in the same cycle is ignored.
- Arithmetic: counters are modulo 2^CNT_W. When an increment wraps all-ones to 0, the matching ovf_o bit is set and stays set until clear or reset.
- Read port, 1-cycle latency: rd_data_o takes the selected counter's value as held before that edge's update.
  - rd_sel_i 0..NUM_EVT-1 selects an event counter.
  - rd_sel_i NUM_EVT selects the cycle counter.
  - Any larger rd_sel_i returns 0.
  - Reads are valid in every state.
- running_o and done_o are registered and decoded directly from state.

Optional Feature:
PERF_SATURATE_EN
- Defined: every counter saturates at all-ones instead of wrapping. Its ovf_o bit sets on the first increment attempted while saturated.
- With a saturated cycle counter and limit 0, the block stays in RUN.
- Undefined: modulo wrap as specified above.

Decomposition:
- Package perf_pkg holds:
  - state enum (IDLE=0, RUN=1, DONE=2)
  - default CNT_W and LIM_W constants
  - read-select constant SEL_CYCLE = NUM_EVT, computed in the top
- One sub-module, perf_evt_counter: one CNT_W counter with increment enable, clear, and sticky overflow, honouring PERF_SATURATE_EN. Instantiated NUM_EVT+1 times: the event channels plus the cycle counter.

Test Plan:
(NUM_EVT=2, CNT_W=8 unless noted)
1. Reset; start with limit 10; evt[0] held high; evt[1] high on alternate cycles -> done_o=1 after exactly 10 RUN edges; cnt0=10, cnt1=5, cycle=10. rd_sel=2 returns 10 one cycle later.
2. limit 0; evt[0] high for 256 cycles -> cnt0=0, ovf_o[0]=1. Repeat with PERF_SATURATE_EN -> cnt0=255, ovf_o[0]=1 on cycle 256.
3. limit 20; freeze_i high for 5 cycles mid-run with evt[0] high -> DONE on the 25th RUN edge; cycle=20, cnt0=20.
4. clear_i and start_i together in IDLE -> stays IDLE. clear_i with evt high in RUN at count 6 -> all counters 0, ovf_o 0, IDLE next edge.
5. rst_i at RUN cycle 7 -> next edge all outputs 0, state IDLE. In DONE, start_i=1 -> no restart; counters hold.
6. rd_sel_i=3 (out of range) -> rd_data_o=0. rd_sel_i=0 on the edge cnt0 goes 4->5 -> rd_data_o reads 4.
